// File: rtl/c_err_sched_if.sv
// Report channel of the error scheduler: one coalesced error event per valid/ready transfer.
interface c_err_sched_if #(
    parameter int unsigned num_errors  = 8,
    parameter int unsigned count_width = 4
);
    localparam int unsigned idx_width = $clog2(num_errors);

    logic                   rpt_valid;
    logic                   rpt_ready;
    logic [0:idx_width-1]   rpt_index;
    logic [0:count_width-1] rpt_count;

    modport master (
        output rpt_valid,
        output rpt_index,
        output rpt_count,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_index,
        input  rpt_count,
        output rpt_ready
    );
endinterface

// File: rtl/c_err_sched.sv
// Sticky error collector: per-input pending flag plus saturating occurrence count,
// drained one report at a time over a valid/ready channel with round-robin arbitration.
module c_err_sched #(
    parameter int unsigned num_errors  = 8,
    parameter int unsigned count_width = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic [0:num_errors-1] errors_in,
    input  logic [0:num_errors-1] mask,
    output logic [0:num_errors-1] pending,
    output logic                  any_pending,
    c_err_sched_if.master         rpt
);
    localparam int unsigned idx_width = $clog2(num_errors);
    localparam logic [0:count_width-1] cnt_max = '1;

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e                 state_q;
    logic [0:num_errors-1]  ev;
    logic [0:num_errors-1]  pend_q;
    logic [0:count_width-1] cnt_q [num_errors];
    logic [0:idx_width-1]   ptr_q;
    logic [0:idx_width-1]   ptr_nxt;
    logic [0:idx_width-1]   win_idx;
    logic                   rpt_valid_q;
    logic [0:idx_width-1]   rpt_index_q;
    logic [0:count_width-1] rpt_count_q;

    assign ev = errors_in & ~mask;

    // Scan downward so the pending index closest to (at or after) ptr wins.
    always_comb begin
        int j;
        int n;
        win_idx = '0;
        for (int k = int'(num_errors) - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= int'(num_errors)) begin
                j = j - int'(num_errors);
            end
            if (pend_q[j]) begin
                win_idx = idx_width'(j);
            end
        end
        n = int'(rpt_index_q) + 1;
        if (n >= int'(num_errors)) begin
            n = 0;
        end
        ptr_nxt = idx_width'(n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pend_q      <= '0;
            ptr_q       <= '0;
            rpt_valid_q <= 1'b0;
            rpt_index_q <= '0;
            rpt_count_q <= '0;
            for (int i = 0; i < int'(num_errors); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (active) begin
            for (int i = 0; i < int'(num_errors); i++) begin
                if (ev[i]) begin
                    pend_q[i] <= 1'b1;
                    if (cnt_q[i] != cnt_max) begin
                        cnt_q[i] <= cnt_q[i] + count_width'(1);
                    end
                end
            end
            case (state_q)
                StIdle: begin
                    if (|pend_q) begin
                        rpt_index_q <= win_idx;
                        rpt_count_q <= cnt_q[win_idx];
                        // A same-cycle occurrence on the winner restarts its tally at one.
                        pend_q[win_idx] <= ev[win_idx];
                        cnt_q[win_idx]  <= ev[win_idx] ? count_width'(1) : '0;
                        rpt_valid_q     <= 1'b1;
                        state_q         <= StPresent;
                    end
                end
                StPresent: begin
                    if (rpt.rpt_ready) begin
                        ptr_q       <= ptr_nxt;
                        rpt_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pending       = pend_q;
    assign any_pending   = (|pend_q) | rpt_valid_q;
    assign rpt.rpt_valid = rpt_valid_q;
    assign rpt.rpt_index = rpt_index_q;
    assign rpt.rpt_count = rpt_count_q;
endmodule

// File: tb/tb_c_err_sched.sv
// Directed bench for c_err_sched: cycle-by-cycle vector table plus saturation and
// backpressure-coalescing sequences.
module tb_c_err_sched;
    logic       clk;
    logic       reset;
    logic       active;
    logic [0:7] errors_in;
    logic [0:7] mask;
    logic [0:7] pending;
    logic       any_pending;

    c_err_sched_if #(.num_errors(8), .count_width(4)) rpt_if ();

    c_err_sched #(.num_errors(8), .count_width(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .errors_in   (errors_in),
        .mask        (mask),
        .pending     (pending),
        .any_pending (any_pending),
        .rpt         (rpt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         act;
        logic [0:7] err;
        logic [0:7] msk;
        bit         rdy;
        bit         exp_v;
        int         exp_idx;
        int         exp_cnt;
        logic [0:7] exp_pend;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input bit rst, input bit act, input logic [0:7] err,
                       input logic [0:7] msk, input bit rdy, input bit ev, input int ei,
                       input int ec, input logic [0:7] ep, input string nm);
        vec_t v;
        v.rst = rst; v.act = act; v.err = err; v.msk = msk; v.rdy = rdy;
        v.exp_v = ev; v.exp_idx = ei; v.exp_cnt = ec; v.exp_pend = ep; v.name = nm;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input bit rst, input bit act, input logic [0:7] err,
                        input logic [0:7] msk, input bit rdy);
        @(negedge clk);
        reset            = rst;
        active           = act;
        errors_in        = err;
        mask             = msk;
        rpt_if.rpt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input bit ev, input int ei, input int ec,
                         input logic [0:7] ep);
        bit exp_any;
        exp_any = (|ep) | ev;
        tests++;
        if (rpt_if.rpt_valid !== ev || int'(rpt_if.rpt_index) != ei ||
            int'(rpt_if.rpt_count) != ec || pending !== ep || any_pending !== exp_any) begin
            fails++;
            $display("FAIL %s: got v=%0b idx=%0d cnt=%0d pend=%b any=%0b, want v=%0b idx=%0d cnt=%0d pend=%b any=%0b",
                     nm, rpt_if.rpt_valid, rpt_if.rpt_index, rpt_if.rpt_count, pending,
                     any_pending, ev, ei, ec, ep, exp_any);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        active           = 1'b1;
        errors_in        = '0;
        mask             = '0;
        rpt_if.rpt_ready = 1'b0;

        // Pattern bits read left to right as index 0..7.
        add(1, 1, 8'b00000000, 8'b00000000, 0, 0, 0, 0, 8'b00000000, "rst");
        add(0, 1, 8'b00010000, 8'b00000000, 1, 0, 0, 0, 8'b00010000, "single_pend");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 1, 3, 1, 8'b00000000, "single_load");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 3, 1, 8'b00000000, "single_accept");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 3, 1, 8'b00000000, "single_idle");
        add(1, 1, 8'b00000000, 8'b00000000, 0, 0, 0, 0, 8'b00000000, "rr_rst");
        add(0, 1, 8'b01001010, 8'b00000000, 1, 0, 0, 0, 8'b01001010, "rr_pend");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 1, 1, 1, 8'b00001010, "rr_first1");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 1, 1, 8'b00001010, "rr_bubble1");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 1, 4, 1, 8'b00000010, "rr_then4");
        add(0, 1, 8'b01000010, 8'b00000000, 1, 0, 4, 1, 8'b01000010, "rr_repulse");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 1, 6, 2, 8'b01000000, "rr_then6");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 6, 2, 8'b01000000, "rr_bubble6");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 1, 1, 1, 8'b00000000, "rr_wrap1");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 1, 1, 8'b00000000, "rr_done");
        add(1, 1, 8'b00000000, 8'b00000000, 0, 0, 0, 0, 8'b00000000, "mask_rst");
        add(0, 1, 8'b10000000, 8'b10000000, 1, 0, 0, 0, 8'b00000000, "mask_drop");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 0, 0, 8'b00000000, "mask_none");
        add(0, 1, 8'b10000001, 8'b00000000, 0, 0, 0, 0, 8'b10000001, "mask_pend");
        add(0, 1, 8'b00000000, 8'b00000001, 0, 1, 0, 1, 8'b00000001, "mask_first0");
        add(0, 1, 8'b00000000, 8'b00000001, 1, 0, 0, 1, 8'b00000001, "mask_keep7");
        add(0, 1, 8'b00000000, 8'b00000001, 0, 1, 7, 1, 8'b00000000, "mask_rpt7");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 7, 1, 8'b00000000, "mask_done");
        add(0, 1, 8'b00100000, 8'b00000000, 0, 0, 7, 1, 8'b00100000, "rst_pend");
        add(0, 1, 8'b00000000, 8'b00000000, 0, 1, 2, 1, 8'b00000000, "rst_load");
        add(0, 1, 8'b00000001, 8'b00000000, 1, 0, 2, 1, 8'b00000001, "rst_acc");
        add(0, 1, 8'b00000000, 8'b00000000, 0, 1, 7, 1, 8'b00000000, "rst_present");
        add(1, 1, 8'b00000000, 8'b00000000, 0, 0, 0, 0, 8'b00000000, "rst_mid");
        add(0, 1, 8'b10010000, 8'b00000000, 0, 0, 0, 0, 8'b10010000, "rst_pend2");
        add(0, 1, 8'b00000000, 8'b00000000, 0, 1, 0, 1, 8'b00010000, "rst_ptr0");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 0, 1, 8'b00010000, "rst_acc2");
        add(0, 1, 8'b00000000, 8'b00000000, 0, 1, 3, 1, 8'b00000000, "rst_next3");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 3, 1, 8'b00000000, "rst_done");
        add(0, 0, 8'b00100000, 8'b00000000, 0, 0, 3, 1, 8'b00000000, "act_ignore");
        add(0, 0, 8'b00000000, 8'b00000000, 0, 0, 3, 1, 8'b00000000, "act_ignore2");
        add(0, 1, 8'b00100000, 8'b00000000, 0, 0, 3, 1, 8'b00100000, "act_pend");
        add(0, 0, 8'b00000000, 8'b00000000, 1, 0, 3, 1, 8'b00100000, "act_hold_idle");
        add(0, 1, 8'b00000000, 8'b00000000, 0, 1, 2, 1, 8'b00000000, "act_load");
        add(0, 0, 8'b00000000, 8'b00000000, 1, 1, 2, 1, 8'b00000000, "act_hold_present");
        add(0, 1, 8'b00000000, 8'b00000000, 1, 0, 2, 1, 8'b00000000, "act_accept");
        add(0, 1, 8'b00000001, 8'b00000000, 0, 0, 2, 1, 8'b00000001, "act_pend7");
        add(1, 0, 8'b00000000, 8'b00000000, 0, 0, 0, 0, 8'b00000000, "rst_inactive");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].act, vecs[i].err, vecs[i].msk, vecs[i].rdy);
            check(vecs[i].name, vecs[i].exp_v, vecs[i].exp_idx, vecs[i].exp_cnt,
                  vecs[i].exp_pend);
        end

        // Saturation: index 2 occurs 20 times while index 0's report is stalled.
        step(1, 1, 8'b00000000, 8'b00000000, 0);
        step(0, 1, 8'b10000000, 8'b00000000, 0);
        check("sat_pend0", 0, 0, 0, 8'b10000000);
        for (int c = 0; c < 20; c++) begin
            step(0, 1, 8'b00100000, 8'b00000000, 0);
        end
        check("sat_hold", 1, 0, 1, 8'b00100000);
        step(0, 1, 8'b00000000, 8'b00000000, 1);
        check("sat_accept", 0, 0, 1, 8'b00100000);
        step(0, 1, 8'b00000000, 8'b00000000, 0);
        check("sat_count", 1, 2, 15, 8'b00000000);

        // Coalescing: three occurrences on index 5 split across two reports (1 + 2).
        step(1, 1, 8'b00000000, 8'b00000000, 0);
        step(0, 1, 8'b00000100, 8'b00000000, 0);
        check("coal_pend", 0, 0, 0, 8'b00000100);
        step(0, 1, 8'b00000100, 8'b00000000, 0);
        check("coal_load", 1, 5, 1, 8'b00000100);
        step(0, 1, 8'b00000100, 8'b00000000, 0);
        check("coal_third", 1, 5, 1, 8'b00000100);
        for (int c = 0; c < 7; c++) begin
            step(0, 1, 8'b00000000, 8'b00000000, 0);
            check("coal_hold", 1, 5, 1, 8'b00000100);
        end
        step(0, 1, 8'b00000000, 8'b00000000, 1);
        check("coal_accept", 0, 5, 1, 8'b00000100);
        step(0, 1, 8'b00000000, 8'b00000000, 0);
        check("coal_second", 1, 5, 2, 8'b00000000);
        step(0, 1, 8'b00000000, 8'b00000000, 1);
        check("coal_done", 0, 5, 2, 8'b00000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/c_err_sched.md
Name: c_err_sched

Overview:
- Collects registered error flags from a bank of error reporters.
- Records each flag as sticky pending, with a saturating count of how many cycles the error occurred.
- Serializes pending errors onto a single valid/ready report channel using round-robin arbitration.
- Sits between the per-router error reporting registers and the top-level error/debug interface, so no error event is lost under backpressure.

Parameters:
- num_errors, 8: number of error inputs; must be >= 2.
- count_width, 4: width of each per-input occurrence counter and of rpt_count; must be >= 1.
- idx_width, clog2(num_errors): width of rpt_index; derived, not overridable.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- active  input  1  clock-enable; all state holds while low.
- errors_in  input  [0:num_errors-1]  raw error flags, level per cycle.
- mask  input  [0:num_errors-1]  1 = ignore this input.
- rpt_valid  output  1  report available.
- rpt_ready  input  1  consumer accepts report.
- rpt_index  output  [0:idx_width-1]  index of the reported error input.
- rpt_count  output  [0:count_width-1]  number of occurrence cycles coalesced into this report.
- pending  output  [0:num_errors-1]  sticky pending flags not yet transferred to the report register.
- any_pending  output  1  OR-reduce of pending, or rpt_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, and takes effect regardless of active.
- Reset values: pending=0, all counters=0, rpt_valid=0, rpt_index=0, rpt_count=0, round-robin pointer=0, FSM=IDLE.
- active=0: no state changes and errors_in is ignored; outputs hold their values.
- Occurrence capture, per input i, each active cycle:
  - ev[i] = errors_in[i] & ~mask[i].
  - If ev[i]=1, set pending[i] and increment cnt[i], saturating at 2^count_width-1.
- Masking: masking an input that is already pending does not clear it; it is still reported with its existing count.
- FSM, two states: IDLE and PRESENT.
- IDLE:
  - If pending is nonzero, pick winner w as the first pending index at or after ptr, wrapping modulo num_errors.
  - Load rpt_index=w and rpt_count=cnt[w].
  - Clear pending[w] and cnt[w]. If ev[w] is 1 in this same cycle, pending[w] is set instead and cnt[w]=1, so nothing is lost.
  - Next state PRESENT, with rpt_valid=1 from the next cycle.
  - Latency: an error sampled in cycle t sets pending at t+1, loads at t+1, and rpt_valid=1 at t+2.
- PRESENT:
  - rpt_valid=1; rpt_index and rpt_count are held stable until accepted.
  - On rpt_ready=1: ptr=(rpt_index+1) mod num_errors, rpt_valid=0, go to IDLE. This gives a one-cycle bubble between consecutive reports.
  - Occurrences on any input, including rpt_index, keep accumulating into pending/cnt during PRESENT.
- rpt_ready while rpt_valid=0 is ignored.
- The round-robin pointer changes only on acceptance.
- Reset mid-PRESENT: the report is discarded and all state returns to reset values on the next edge.

Test Plan:
- Single error: errors_in[3]=1 for 1 cycle, rpt_ready=1 → rpt_valid high exactly 1 cycle, 2 cycles later, with rpt_index=3, rpt_count=1; pending=0 afterwards.
- Round-robin: errors_in[1], [4] and [6] pulsed together, ptr=0, rpt_ready=1 → reports in order 1, 4, 6, each separated by one idle cycle. A second pulse on [1] and [6] after the report for 4 → order 6, 1.
- Saturation: count_width=4, errors_in[2] held 20 cycles while rpt_ready=0 on an earlier report → when index 2 is reported, rpt_count=15.
- Backpressure coalescing: errors_in[5]=1 for 3 cycles, with rpt_ready low for 10 cycles → first report index 5 with count 1 or more, held stable. Remaining occurrences appear in a second report for index 5, and the sum of both counts is 3.
- Mask: mask[0]=1 with errors_in[0] pulsed → no report and pending[0]=0. With pending[7] already set, setting mask[7]=1 → index 7 is still reported.
- Reset and active:
  - reset asserted during PRESENT → next cycle rpt_valid=0, pending=0, ptr=0.
  - active=0 while errors_in[2]=1 → pending unchanged, no report.
